// File: rtl/sw_loader.sv
// sw_loader: synchronises the board switches, waits for a fresh SW[8] press during an
// input instruction and issues one register-file write. Debounce filter: SW_LOADER_DEBOUNCE_EN.
module sw_loader #(
  parameter int n         = 8,
  parameter int DB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   SW_raw,
  input  logic         ld_req,
  input  logic [4:0]   ld_addr,
  output logic         wr_en,
  output logic [4:0]   wr_addr,
  output logic [n-1:0] wr_data,
  output logic         ld_done,
  output logic         stall,
  output logic [1:0]   dbg_state
);

  // CPU handshake: ld_req is a level held from the start of the input instruction until the
  // cycle after ld_done; ld_done is a single-cycle ack, and stall covers every ld_req cycle
  // except the ack itself. Dropping ld_req before ld_done cancels the load without a write.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WRITE        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [9:0] sw_meta;
  logic [9:0] sw_s;
  logic       sw8_db;
  logic       sw8_prev;
  logic       rise;
  logic       in_write;
  logic       unused_sw;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= SW_raw;
      sw_s    <= sw_meta;
    end
  end

`ifdef SW_LOADER_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt;

  // The level only flips after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      sw8_db <= 1'b0;
    end else if (sw_s[8] == sw8_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      sw8_db <= ~sw8_db;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      sw8_db <= 1'b0;
    end else begin
      sw8_db <= sw_s[8];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sw8_prev <= 1'b0;
    end else begin
      sw8_prev <= sw8_db;
    end
  end

  assign rise = sw8_db & ~sw8_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A rise that lands while still in IDLE is deliberately ignored: only presses made
  // after the request was accepted count.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ld_req) state_nx = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!ld_req)   state_nx = IDLE;
        else if (rise) state_nx = WRITE;
      end
      WRITE: begin
        state_nx = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!sw8_db) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (state == IDLE && ld_req) begin
        wr_addr <= ld_addr;
      end
      if (state == WAIT_PRESS && ld_req && rise) begin
        wr_data <= sw_s[n-1:0];
      end
    end
  end

  // Reset masks the strobes combinationally so a reset landing in WRITE never leaks a write.
  always_comb begin
    in_write  = (state == WRITE) && !reset;
    ld_done   = in_write;
    wr_en     = in_write && (wr_addr != 5'd0);
    stall     = ld_req & ~in_write;
    dbg_state = state;
  end

  assign unused_sw = ^sw_s;

endmodule

// File: tb/tb_sw_loader.sv
// Directed bench for sw_loader: table-driven loads plus hand-written bounce, pre-held key,
// cancel and reset sequences. Latency expectations follow SW_LOADER_DEBOUNCE_EN.
module tb_sw_loader;
  localparam int N  = 8;
  localparam int DB = 4;
`ifdef SW_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 2 + 1 + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   SW_raw;
  logic         ld_req;
  logic [4:0]   ld_addr;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         ld_done;
  logic         stall;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_wr   = 0;
  int n_done = 0;

  logic [12:0] exp_q[$];

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       exp_en;
    logic [4:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  sw_loader #(.n(N), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .SW_raw    (SW_raw),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ld_done   (ld_done),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (ld_done === 1'b1) n_done++;
    if (wr_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write", wr_addr, wr_data);
      end else begin
        chk("sb_write", {19'd0, wr_addr, wr_data}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b1;
    while (cnt < 40) begin
      cyc();
      cnt++;
      #3;
      if (ld_done === 1'b1) break;
      if (stall !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic release_key();
    cyc();
    SW_raw[8] = 1'b0;
    repeat (LAT + 2) cyc();
    #3;
    chk("release_idle", 32'(dbg_state), 32'd0);
  endtask

  task automatic run_load(input int i);
    int cnt;
    bit ok;
    int w0, d0;
    cyc();
    SW_raw  = {2'b00, vecs[i].data};
    ld_req  = 1'b1;
    ld_addr = vecs[i].addr;
    #3;
    chk($sformatf("v%0d_stall_req", i), 32'(stall), 32'd1);
    repeat (3) cyc();
    #3;
    chk($sformatf("v%0d_armed", i), 32'(dbg_state), 32'd1);
    if (vecs[i].exp_en) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
    w0 = n_wr;
    d0 = n_done;
    cyc();
    SW_raw[8] = 1'b1;
    wait_done(cnt, ok);
    chk($sformatf("v%0d_latency", i), 32'(cnt), 32'(LAT));
    chk($sformatf("v%0d_stall_before", i), 32'(ok), 32'd1);
    chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_en));
    chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
    chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].exp_data));
    chk($sformatf("v%0d_stall_ack", i), 32'(stall), 32'd0);
    cyc();
    ld_req      = 1'b0;
    SW_raw[7:0] = ~vecs[i].data;
    #3;
    chk($sformatf("v%0d_done_one_cycle", i), 32'(ld_done), 32'd0);
    repeat (LAT + 2) cyc();
    #3;
    chk($sformatf("v%0d_data_hold", i), 32'(wr_data), 32'(vecs[i].exp_data));
    chk($sformatf("v%0d_wr_count", i), 32'(n_wr - w0), 32'(vecs[i].exp_en));
    chk($sformatf("v%0d_done_count", i), 32'(n_done - d0), 32'd1);
    release_key();
  endtask

  initial begin
    int cnt;
    bit ok;
    int w0, d0;

    vecs[0] = '{5'd5,  8'hA5, 1'b1, 5'd5,  8'hA5};
    vecs[1] = '{5'd31, 8'h3C, 1'b1, 5'd31, 8'h3C};
    vecs[2] = '{5'd0,  8'hFF, 1'b0, 5'd0,  8'hFF};
    vecs[3] = '{5'd17, 8'h00, 1'b1, 5'd17, 8'h00};

    reset   = 1'b1;
    SW_raw  = '0;
    ld_req  = 1'b0;
    ld_addr = '0;
    repeat (3) cyc();
    #3;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    cyc();
    reset = 1'b0;
    #3;
    chk("idle_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 4; i++) run_load(i);

`ifdef SW_LOADER_DEBOUNCE_EN
    // Bounce: SW8 toggles every cycle, then stays high.
    cyc();
    ld_req  = 1'b1;
    ld_addr = 5'd9;
    SW_raw  = {2'b00, 8'h5A};
    exp_q.push_back({5'd9, 8'h5A});
    w0 = n_wr;
    repeat (2) cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      SW_raw[8] = (k % 2 == 0);
    end
    cyc();
    SW_raw[8] = 1'b1;
    wait_done(cnt, ok);
    chk("bounce_latency", 32'(cnt), 32'(LAT));
    chk("bounce_no_early_write", 32'(n_wr - w0), 32'd0);
    chk("bounce_wr_en", 32'(wr_en), 32'd1);
    cyc();
    ld_req = 1'b0;
    repeat (LAT) cyc();
    #3;
    chk("bounce_wr_count", 32'(n_wr - w0), 32'd1);
    release_key();
`endif

    // Pre-held key: debounced high before the request arrives.
    cyc();
    SW_raw = {2'b01, 8'h42};
    repeat (LAT + 2) cyc();
    cyc();
    ld_req  = 1'b1;
    ld_addr = 5'd7;
    d0 = n_done;
    repeat (10) cyc();
    #3;
    chk("held_no_done", 32'(n_done - d0), 32'd0);
    chk("held_state", 32'(dbg_state), 32'd1);
    cyc();
    SW_raw[8] = 1'b0;
    repeat (LAT + 2) cyc();
    #3;
    chk("held_release_no_done", 32'(n_done - d0), 32'd0);
    exp_q.push_back({5'd7, 8'h42});
    cyc();
    SW_raw[8] = 1'b1;
    wait_done(cnt, ok);
    chk("held_latency", 32'(cnt), 32'(LAT));
    chk("held_wr_addr", 32'(wr_addr), 32'd7);
    chk("held_wr_data", 32'(wr_data), 32'h42);
    // A new request while the key is still down must wait for release.
    cyc();
    ld_addr     = 5'd3;
    SW_raw[7:0] = 8'h66;
    repeat (8) cyc();
    #3;
    chk("rereq_state", 32'(dbg_state), 32'd3);
    chk("rereq_stall", 32'(stall), 32'd1);
    chk("rereq_no_done", 32'(n_done - d0), 32'd1);
    exp_q.push_back({5'd3, 8'h66});
    cyc();
    SW_raw[8] = 1'b0;
    repeat (LAT + 2) cyc();
    #3;
    chk("rereq_armed", 32'(dbg_state), 32'd1);
    cyc();
    SW_raw[8] = 1'b1;
    wait_done(cnt, ok);
    chk("rereq_latency", 32'(cnt), 32'(LAT));
    chk("rereq_wr_addr", 32'(wr_addr), 32'd3);
    chk("rereq_wr_data", 32'(wr_data), 32'h66);
    cyc();
    ld_req = 1'b0;
    release_key();
    chk("held_done_total", 32'(n_done - d0), 32'd2);

    // Cancel: ld_req drops in the same cycle the debounced rise arrives.
    cyc();
    SW_raw  = {2'b00, 8'h77};
    ld_req  = 1'b1;
    ld_addr = 5'd12;
    repeat (3) cyc();
    d0 = n_done;
    w0 = n_wr;
    cyc();
    SW_raw[8] = 1'b1;
    repeat (LAT - 1) cyc();
    ld_req = 1'b0;
    repeat (4) cyc();
    #3;
    chk("cancel_no_done", 32'(n_done - d0), 32'd0);
    chk("cancel_no_write", 32'(n_wr - w0), 32'd0);
    chk("cancel_state", 32'(dbg_state), 32'd0);
    chk("cancel_no_capture", 32'(wr_data), 32'h66);
    chk("cancel_wr_addr", 32'(wr_addr), 32'd12);
    release_key();

    // Reset asserted while in WRITE.
    cyc();
    SW_raw  = {2'b00, 8'h99};
    ld_req  = 1'b1;
    ld_addr = 5'd20;
    repeat (3) cyc();
    cyc();
    SW_raw[8] = 1'b1;
    wait_done(cnt, ok);
    chk("rstw_latency", 32'(cnt), 32'(LAT));
    reset = 1'b1;
    cyc();
    #3;
    chk("rstw_wr_en", 32'(wr_en), 32'd0);
    chk("rstw_ld_done", 32'(ld_done), 32'd0);
    chk("rstw_wr_addr", 32'(wr_addr), 32'd0);
    chk("rstw_wr_data", 32'(wr_data), 32'd0);
    chk("rstw_state", 32'(dbg_state), 32'd0);
    cyc();
    #3;
    chk("rstw2_wr_en", 32'(wr_en), 32'd0);
    chk("rstw2_ld_done", 32'(ld_done), 32'd0);
    reset  = 1'b0;
    ld_req = 1'b0;
    repeat (LAT + 2) cyc();
    release_key();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
